traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised multi-phase traffic-signal controller for the VGA road-control system, generalising the two-way red/green signal unit. It rotates through N_PHASES approaches, each with GREEN → YELLOW → ALL_RED intervals. Each approach's green time is chosen as long or short from a per-approach traffic-density flag supplied by the image-processing path. An optional pedestrian interval can be compiled in. Outputs drive the on-screen signal renderer and a countdown display.

## Interface
- TICK_DIV, 100_000_000: clk cycles per one-second tick (≥2; benches use 4)
- N_PHASES, 2: number of approaches, 2..4
- CNT_W, 5: width of second counters; must hold every *_SEC value
- GREEN_LONG_SEC, 30: green time when the approach is dense
- GREEN_SHORT_SEC, 10: green time when the approach is sparse
- YELLOW_SEC, 3: yellow time, ≥1
- ALL_RED_SEC, 1: all-red clearance time, ≥1
- PED_SEC, 8: pedestrian walk time (only with PED_REQ_EN)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- density_hi  in  N_PHASES  per-approach dense flag from vision, bit p = approach p
- density_valid  in  1  density_hi qualifier, single-cycle strobe
- light_o  out  2*N_PHASES  per-approach code at [2p+1:2p]: 00 red, 01 yellow, 10 green
- phase_idx  out  $clog2(N_PHASES)  approach currently owning the cycle
- remain_sec  out  CNT_W  seconds left in the current interval
- tr_valid  out  1  one-cycle pulse: density snapshot accepted
- light_valid  out  1  one-cycle pulse on every interval change
- ped_req  in  1  pedestrian button, level or pulse (PED_REQ_EN only)
- ped_walk  out  1  walk indication (PED_REQ_EN only)

## Operation
- Tick generator: counter 0..TICK_DIV-1. tick is high for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
- Density latch: on density_valid, dens_q <= density_hi and tr_valid=1 the next cycle. The latch is sampled only on GREEN entry; changes mid-green never alter a running green.
- FSM states:
  - GREEN: light_o[p]=10, all others 00. Duration is dens_q[p] ? GREEN_LONG_SEC : GREEN_SHORT_SEC.
  - YELLOW: light_o[p]=01, others 00. Duration YELLOW_SEC.
  - ALL_RED: all 00. Duration ALL_RED_SEC.
  - PED (macro only): all 00, ped_walk=1. Duration PED_SEC.
- Transitions:
  - GREEN → YELLOW → ALL_RED.
  - ALL_RED → GREEN of (phase_idx+1) mod N_PHASES.
  - With macro: ALL_RED of the last phase (phase_idx=N_PHASES-1) with a pending request → PED → GREEN of phase 0.
- Countdown:
  - On interval entry, remain_sec loads the interval duration.
  - Each tick, remain_sec decrements.
  - A tick while remain_sec==1 ends the interval; the next interval's load occurs on that same clk edge.
  - Every interval therefore lasts exactly its duration in ticks, and remain_sec never shows 0.
- light_valid pulses in the cycle after each state/phase change.
- phase_idx is unchanged through YELLOW/ALL_RED/PED and advances on GREEN entry only.

## Timing
- All outputs are registered.
- Reset values:
  - FSM GREEN, phase_idx=0, dens_q=0, remain_sec=GREEN_SHORT_SEC.
  - light_o: approach 0 = 10, others 00.
  - tr_valid=0, light_valid=0, ped_walk=0, ped pending=0, tick counter=0.
- First tick occurs TICK_DIV cycles after reset deassertion.
- Density to effect: density_valid at cycle t → tr_valid at t+1. It affects the next GREEN entry whose edge is at t+1 or later. A GREEN entry on the same edge as density_valid uses the old dens_q.
- Reset mid-interval returns to the reset state on the next edge regardless of FSM state or tick.
- phase_idx wraps N_PHASES-1 → 0. For non-power-of-two N_PHASES, unused codes are never reached.
- Simultaneous density_valid and tick: both take effect; there is no priority conflict.
- Parameter guard: elaboration fails if any duration ≥ 2**CNT_W or N_PHASES is outside 2..4.

## Configuration
- PED_REQ_EN defined:
  - ped_req/ped_walk ports exist.
  - A ped_req high in any cycle sets the pending flag.
  - The pending flag is cleared on PED entry. A request on that same edge is consumed, not re-latched.
  - A request during PED is latched for the next cycle.
- PED_REQ_EN undefined:
  - No ped ports and no PED state.
  - The sequence is GREEN/YELLOW/ALL_RED only.

## Test plan
- Reset, TICK_DIV=4, N_PHASES=2, dens_q=0 → phase 0 green remain 10. YELLOW entry after 40 clk, remain 3. ALL_RED after 12 more clk. Phase 1 GREEN after 4 more; light_valid pulses at each change.
- density_valid with density_hi=2'b10 during phase 0 green → tr_valid the next cycle; phase 0 green stays 10 s; phase 1 green loads 30.
- density_valid on the same edge as phase 1 GREEN entry → phase 1 uses the old dens_q (10 s); a later phase 1 entry uses the new value.
- N_PHASES=3: phase_idx sequence 0,1,2,0 with light_o codes 10/01/00 per slot; remain_sec never 0.
- Reset asserted mid-YELLOW of phase 1 → next edge shows phase 0 GREEN, remain 10, all pulses 0.
- PED_REQ_EN, ped_req pulse during phase 0 → after phase N-1 ALL_RED, ped_walk=1 for 8 ticks, all red, then phase 0 green. A second run without a request skips PED.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: multi-approach traffic signal sequencer.
// Each approach in turn runs GREEN -> YELLOW -> ALL_RED; the green length is
// long or short according to the latched per-approach density flag.
// Optional pedestrian interval after the last approach: define PED_REQ_EN.
// Handshake: density_valid is a single-cycle strobe that always accepts
// density_hi (no back-pressure); tr_valid and light_valid are one-cycle
// registered pulses with no ready.
module traffic_phase_ctrl #(
   parameter int TICK_DIV        = 100_000_000,
   parameter int N_PHASES        = 2,
   parameter int CNT_W           = 5,
   parameter int GREEN_LONG_SEC  = 30,
   parameter int GREEN_SHORT_SEC = 10,
   parameter int YELLOW_SEC      = 3,
   parameter int ALL_RED_SEC     = 1,
   parameter int PED_SEC         = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_PHASES-1:0]           density_hi,
   input  logic                          density_valid,
   output logic [2*N_PHASES-1:0]         light_o,
   output logic [$clog2(N_PHASES)-1:0]   phase_idx,
   output logic [CNT_W-1:0]              remain_sec,
   output logic                          tr_valid,
   output logic                          light_valid
`ifdef PED_REQ_EN
   ,
   input  logic                          ped_req,
   output logic                          ped_walk
`endif
);

   localparam int PH_W   = $clog2(N_PHASES);
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [TICK_W-1:0]     TICK_MAX  = TICK_W'(TICK_DIV - 1);
   localparam logic [PH_W-1:0]       PH_LAST   = PH_W'(N_PHASES - 1);
   localparam logic [CNT_W-1:0]      G_LONG    = CNT_W'(GREEN_LONG_SEC);
   localparam logic [CNT_W-1:0]      G_SHORT   = CNT_W'(GREEN_SHORT_SEC);
   localparam logic [CNT_W-1:0]      Y_LEN     = CNT_W'(YELLOW_SEC);
   localparam logic [CNT_W-1:0]      AR_LEN    = CNT_W'(ALL_RED_SEC);
   localparam logic [CNT_W-1:0]      PED_LEN   = CNT_W'(PED_SEC);
   localparam logic [2*N_PHASES-1:0] LIGHT_RST = (2*N_PHASES)'(2'b10);

   // Elaboration-time guards on the configuration.
   generate
      if (N_PHASES < 2 || N_PHASES > 4) begin : g_bad_phases
         $error("traffic_phase_ctrl: N_PHASES must be 2..4");
      end
      if (TICK_DIV < 2 || YELLOW_SEC < 1 || ALL_RED_SEC < 1 ||
          GREEN_SHORT_SEC < 1 || GREEN_LONG_SEC < 1) begin : g_bad_len
         $error("traffic_phase_ctrl: TICK_DIV >= 2 and every duration >= 1");
      end
      if (GREEN_LONG_SEC >= 2**CNT_W || GREEN_SHORT_SEC >= 2**CNT_W ||
          YELLOW_SEC >= 2**CNT_W || ALL_RED_SEC >= 2**CNT_W) begin : g_bad_w
         $error("traffic_phase_ctrl: a duration does not fit in CNT_W");
      end
`ifdef PED_REQ_EN
      if (PED_SEC < 1 || PED_SEC >= 2**CNT_W) begin : g_bad_ped
         $error("traffic_phase_ctrl: PED_SEC out of range");
      end
`endif
   endgenerate

   typedef enum logic [1:0] {
      S_GREEN   = 2'd0,
      S_YELLOW  = 2'd1,
      S_ALL_RED = 2'd2,
      S_PED     = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [PH_W-1:0]         phase_q, phase_d, phase_nxt;
   logic [CNT_W-1:0]        remain_q, remain_d;
   logic [N_PHASES-1:0]     dens_q, dens_d;
   logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
   logic [2*N_PHASES-1:0]   light_q, light_d;
   logic                    light_valid_q, light_valid_d;
   logic                    tr_valid_q, tr_valid_d;
   logic                    tick;
   logic                    interval_end;
   logic                    go_ped;

   // One-second tick generator and end-of-interval detection.
   always_comb begin
      tick         = (tick_cnt_q == TICK_MAX);
      tick_cnt_d   = tick ? '0 : tick_cnt_q + TICK_W'(1);
      interval_end = tick && (remain_q == CNT_W'(1));
   end

`ifdef PED_REQ_EN
   logic ped_pend_q, ped_pend_d;
   logic ped_walk_q, ped_walk_d;

   // Walk is inserted only after the last approach's clearance with a request pending.
   always_comb begin
      go_ped     = (state_q == S_ALL_RED) && (phase_q == PH_LAST) && ped_pend_q;
      ped_walk_d = (state_d == S_PED);
      if (interval_end && go_ped) begin
         ped_pend_d = 1'b0;
      end else if (ped_req) begin
         ped_pend_d = 1'b1;
      end else begin
         ped_pend_d = ped_pend_q;
      end
   end

   // Pedestrian pending flag and walk output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ped_pend_q <= 1'b0;
         ped_walk_q <= 1'b0;
      end else begin
         ped_pend_q <= ped_pend_d;
         ped_walk_q <= ped_walk_d;
      end
   end

   assign ped_walk = ped_walk_q;
`else
   // Without the pedestrian option the walk interval never runs.
   always_comb begin
      go_ped = 1'b0;
   end
`endif

   // Next interval: sequence, phase rotation and countdown load/decrement.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      remain_d  = remain_q;
      phase_nxt = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      if (interval_end) begin
         case (state_q)
            S_GREEN: begin
               state_d  = S_YELLOW;
               remain_d = Y_LEN;
            end
            S_YELLOW: begin
               state_d  = S_ALL_RED;
               remain_d = AR_LEN;
            end
            S_ALL_RED: begin
               if (go_ped) begin
                  state_d  = S_PED;
                  remain_d = PED_LEN;
               end else begin
                  state_d  = S_GREEN;
                  phase_d  = phase_nxt;
                  remain_d = dens_q[phase_nxt] ? G_LONG : G_SHORT;
               end
            end
            default: begin
               state_d  = S_GREEN;
               phase_d  = '0;
               remain_d = dens_q[0] ? G_LONG : G_SHORT;
            end
         endcase
      end else if (tick) begin
         remain_d = remain_q - CNT_W'(1);
      end
   end

   // Registered outputs derived from the upcoming interval.
   always_comb begin
      light_d = '0;
      for (int p = 0; p < N_PHASES; p++) begin
         if (PH_W'(p) == phase_d) begin
            if (state_d == S_GREEN) begin
               light_d[2*p +: 2] = 2'b10;
            end else if (state_d == S_YELLOW) begin
               light_d[2*p +: 2] = 2'b01;
            end
         end
      end
      light_valid_d = interval_end;
      tr_valid_d    = density_valid;
      dens_d        = density_valid ? density_hi : dens_q;
   end

   // State, counters and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_GREEN;
         phase_q       <= '0;
         remain_q      <= G_SHORT;
         dens_q        <= '0;
         tick_cnt_q    <= '0;
         light_q       <= LIGHT_RST;
         light_valid_q <= 1'b0;
         tr_valid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         remain_q      <= remain_d;
         dens_q        <= dens_d;
         tick_cnt_q    <= tick_cnt_d;
         light_q       <= light_d;
         light_valid_q <= light_valid_d;
         tr_valid_q    <= tr_valid_d;
      end
   end

   assign light_o     = light_q;
   assign phase_idx   = phase_q;
   assign remain_sec  = remain_q;
   assign tr_valid    = tr_valid_q;
   assign light_valid = light_valid_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl with TICK_DIV=4, three approaches.
// Reference model tracks cycles since reset, the current interval kind,
// its length and ticks elapsed; expected outputs follow from those.
module tb_traffic_phase_ctrl;

   localparam int TICK_DIV = 4;
   localparam int N        = 3;
   localparam int CNT_W    = 5;
   localparam int G_LONG   = 30;
   localparam int G_SHORT  = 10;
   localparam int Y_SEC    = 3;
   localparam int AR_SEC   = 1;
   localparam int P_SEC    = 8;
`ifdef PED_REQ_EN
   localparam bit PED_EN = 1'b1;
`else
   localparam bit PED_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     density_hi = '0;
   logic             density_valid = 1'b0;
   logic             ped_req = 1'b0;
   logic [2*N-1:0]   light_o;
   logic [1:0]       phase_idx;
   logic [CNT_W-1:0] remain_sec;
   logic             tr_valid;
   logic             light_valid;
`ifdef PED_REQ_EN
   logic             ped_walk;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   // Clock.
   always #5 clk = ~clk;

   traffic_phase_ctrl #(
      .TICK_DIV(TICK_DIV), .N_PHASES(N), .CNT_W(CNT_W),
      .GREEN_LONG_SEC(G_LONG), .GREEN_SHORT_SEC(G_SHORT),
      .YELLOW_SEC(Y_SEC), .ALL_RED_SEC(AR_SEC), .PED_SEC(P_SEC)
   ) u_dut (
      .clk(clk),
      .reset(reset),
      .density_hi(density_hi),
      .density_valid(density_valid),
      .light_o(light_o),
      .phase_idx(phase_idx),
      .remain_sec(remain_sec),
      .tr_valid(tr_valid),
      .light_valid(light_valid)
`ifdef PED_REQ_EN
      ,
      .ped_req(ped_req),
      .ped_walk(ped_walk)
`endif
   );

   // Model: kind 0 green, 1 yellow, 2 all-red, 3 walk.
   int           m_cyc     = 0;
   int           m_kind    = 0;
   int           m_phase   = 0;
   int           m_dur     = G_SHORT;
   int           m_elapsed = 0;
   logic [N-1:0] m_dens    = '0;
   bit           m_pend    = 1'b0;
   bit           m_trv     = 1'b0;
   bit           m_lv      = 1'b0;

   function automatic logic [2*N-1:0] exp_light(input int kind, input int ph);
      logic [2*N-1:0] v;
      v = '0;
      for (int p = 0; p < N; p++) begin
         if (p == ph && kind == 0) v[2*p +: 2] = 2'b10;
         if (p == ph && kind == 1) v[2*p +: 2] = 2'b01;
      end
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d t=%0t got=%0h exp=%0h", nm, cyc, $time, act, exp);
      end
   endtask

   // Model advances on each rising edge from the inputs presented there.
   always @(posedge clk) begin
      bit           tk;
      bit           ent_ped;
      logic [N-1:0] old_d;
      if (reset) begin
         m_cyc = 0; m_kind = 0; m_phase = 0; m_dur = G_SHORT; m_elapsed = 0;
         m_dens = '0; m_pend = 1'b0; m_trv = 1'b0; m_lv = 1'b0;
      end else begin
         tk      = (m_cyc % TICK_DIV) == (TICK_DIV - 1);
         m_cyc   = m_cyc + 1;
         old_d   = m_dens;
         ent_ped = 1'b0;
         m_lv    = 1'b0;
         if (tk) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == m_dur) begin
               m_lv = 1'b1;
               m_elapsed = 0;
               case (m_kind)
                  0: begin m_kind = 1; m_dur = Y_SEC; end
                  1: begin m_kind = 2; m_dur = AR_SEC; end
                  2: begin
                     if (PED_EN && m_phase == N - 1 && m_pend) begin
                        m_kind = 3; m_dur = P_SEC; ent_ped = 1'b1;
                     end else begin
                        m_phase = (m_phase + 1) % N;
                        m_kind  = 0;
                        m_dur   = old_d[m_phase] ? G_LONG : G_SHORT;
                     end
                  end
                  default: begin
                     m_phase = 0; m_kind = 0;
                     m_dur = old_d[0] ? G_LONG : G_SHORT;
                  end
               endcase
            end
         end
         if (ent_ped) m_pend = 1'b0;
         else if (PED_EN && ped_req) m_pend = 1'b1;
         m_trv = density_valid;
         if (density_valid) m_dens = density_hi;
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("light_o", light_o, exp_light(m_kind, m_phase));
         chk("phase_idx", phase_idx, m_phase);
         chk("remain_sec", remain_sec, m_dur - m_elapsed);
         chk("tr_valid", tr_valid, m_trv);
         chk("light_valid", light_valid, m_lv);
         chk("remain_nonzero", (remain_sec != 0), 1);
`ifdef PED_REQ_EN
         chk("ped_walk", ped_walk, (m_kind == 3));
`endif
      end
   end

   task automatic wait_to(input int t);
      while (cyc < t) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // Directed pins followed by random traffic.
   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      chk_en = 1'b1;
      chk("rst_light", light_o, 6'b000010);
      chk("rst_phase", phase_idx, 0);
      chk("rst_remain", remain_sec, 10);
      chk("rst_lv", light_valid, 0);
      chk("rst_trv", tr_valid, 0);

      wait_to(5);  density_valid = 1'b1; density_hi = 3'b010;
      wait_to(6);  density_valid = 1'b0;
      chk("trv_pulse", tr_valid, 1);
      wait_to(7);  chk("trv_drop", tr_valid, 0);
      wait_to(39); chk("g0_last_remain", remain_sec, 1);
      chk("g0_last_light", light_o, 6'b000010);
      wait_to(40); chk("y0_light", light_o, 6'b000001);
      chk("y0_remain", remain_sec, 3);
      chk("y0_lv", light_valid, 1);
      wait_to(41); chk("y0_lv_drop", light_valid, 0);
      wait_to(52); chk("ar0_light", light_o, 6'b000000);
      chk("ar0_remain", remain_sec, 1);
      chk("ar0_lv", light_valid, 1);
      wait_to(55); density_valid = 1'b1; density_hi = 3'b000;
      wait_to(56); density_valid = 1'b0;
      chk("g1_phase", phase_idx, 1);
      chk("g1_light", light_o, 6'b001000);
      chk("g1_long_old_dens", remain_sec, 30);
      chk("g1_trv", tr_valid, 1);
      wait_to(248); chk("wrap_phase", phase_idx, 0);
      chk("wrap_light", light_o, 6'b000010);
      wait_to(304); chk("g1b_phase", phase_idx, 1);
      chk("g1b_new_dens", remain_sec, 10);
      wait_to(347); chk("y1_light", light_o, 6'b000100);
      wait_to(348); reset = 1'b1; density_valid = 1'b1; density_hi = 3'b111;
      wait_to(349);
      chk("mid_rst_light", light_o, 6'b000010);
      chk("mid_rst_phase", phase_idx, 0);
      chk("mid_rst_remain", remain_sec, 10);
      chk("mid_rst_lv", light_valid, 0);
      chk("mid_rst_trv", tr_valid, 0);
      reset = 1'b0; density_valid = 1'b0;
      cyc = 0;

      wait_to(2); ped_req = 1'b1;
      wait_to(3); ped_req = 1'b0;
      wait_to(168);
`ifdef PED_REQ_EN
      chk("ped_walk_on", ped_walk, 1);
      chk("ped_light", light_o, 6'b000000);
      chk("ped_remain", remain_sec, 8);
      chk("ped_phase", phase_idx, 2);
      wait_to(200);
      chk("post_ped_light", light_o, 6'b000010);
      chk("post_ped_walk", ped_walk, 0);
      wait_to(368);
      chk("no_req_skip_light", light_o, 6'b000010);
      chk("no_req_skip_walk", ped_walk, 0);
`else
      chk("rot_light", light_o, 6'b000010);
      chk("rot_remain", remain_sec, 10);
`endif

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         cyc++;
         density_valid = ($urandom_range(0, 7) == 0);
         density_hi    = N'($urandom_range(0, (1 << N) - 1));
         ped_req       = ($urandom_range(0, 59) == 0);
         reset         = ($urandom_range(0, 799) == 0);
      end
      @(negedge clk);
      reset = 1'b0;
      density_valid = 1'b0;
      ped_req = 1'b0;
      repeat (4) @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
